// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter, the LSU and the memory model:
// access formats, arbiter FSM states, grant encoding and the alignment rule.
package mem_pkg;

  localparam logic [1:0] FMT_B = 2'b00;
  localparam logic [1:0] FMT_H = 2'b01;
  localparam logic [1:0] FMT_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_LS = 1'b1
  } gnt_t;

  // Half accesses need addr[0]==0 and word accesses (10 and 11) need addr[1:0]==0.
  function automatic logic misaligned_f(input logic [1:0] addr_lo, input logic [1:0] fmt);
    logic bad;
    bad = 1'b0;
    case (fmt)
      FMT_B:   bad = 1'b0;
      FMT_H:   bad = addr_lo[0];
      default: bad = |addr_lo;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU request/response, LSU request/response and memory port.
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// edge where both valid and ready are 1; the sender holds valid and its
// fields stable until that edge and never withdraws valid before it.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  if_valid;
  logic                  if_ready;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_rvalid;
  logic                  if_rready;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_rerr;

  logic                  ls_valid;
  logic                  ls_ready;
  logic                  ls_we;
  logic [1:0]            ls_format;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [DATA_WIDTH-1:0] ls_wdata;
  logic                  ls_rvalid;
  logic                  ls_rready;
  logic [DATA_WIDTH-1:0] ls_rdata;
  logic                  ls_rerr;

  logic                  mem_req;
  logic                  mem_we;
  logic [1:0]            mem_format;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  // Arbiter view.
  modport slave (
    input  if_valid, if_addr, if_rready,
    input  ls_valid, ls_we, ls_format, ls_addr, ls_wdata, ls_rready,
    input  mem_rdata, mem_ack,
    output if_ready, if_rvalid, if_rdata, if_rerr,
    output ls_ready, ls_rvalid, ls_rdata, ls_rerr,
    output mem_req, mem_we, mem_format, mem_addr, mem_wdata
  );

  // Requesters and memory view.
  modport master (
    output if_valid, if_addr, if_rready,
    output ls_valid, ls_we, ls_format, ls_addr, ls_wdata, ls_rready,
    output mem_rdata, mem_ack,
    input  if_ready, if_rvalid, if_rdata, if_rerr,
    input  ls_ready, ls_rvalid, ls_rdata, ls_rerr,
    input  mem_req, mem_we, mem_format, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_align_chk.sv
// Flags an access whose address is not aligned to its size.
module mem_align_chk
  import mem_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [1:0] format,
  output logic       misaligned
);

  assign misaligned = misaligned_f(addr_lo, format);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between IFU and LSU. One transaction in
// flight: IDLE accepts a request, WAIT drives the memory strobe until ack or
// timeout, RESP presents the response to the granted side. LSU wins ties
// unless IFU has been passed over STARVE_LIMIT times in a row.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus,
  output state_t       fsm_state
);

  localparam int STARVE_W = 8;
  localparam int TCNT_W   = 16;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam bit                  TO_EN      = (TIMEOUT != 0);
  localparam logic [TCNT_W-1:0]   TO_LAST    = TO_EN ? TCNT_W'(TIMEOUT - 1) : '0;

  state_t                state_q, state_d;
  gnt_t                  gnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [1:0]            fmt_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [STARVE_W-1:0]   starve_q;
  logic [TCNT_W-1:0]     tcnt_q;

  logic                  force_if;
  logic                  pick_ls;
  logic                  pick_if;
  logic                  accept;
  logic [1:0]            sel_addr_lo;
  logic [1:0]            sel_fmt;
  logic                  misaligned;
  logic                  timeout_hit;
  logic                  rsp_done;
  logic [DATA_WIDTH-1:0] rd_masked;

  assign fsm_state = state_q;

  // Arbitration is purely combinational and only meaningful in IDLE.
  assign force_if    = bus.if_valid && (starve_q == STARVE_MAX);
  assign pick_ls     = bus.ls_valid && !force_if;
  assign pick_if     = bus.if_valid && !pick_ls;
  assign accept      = (state_q == ST_IDLE) && (pick_ls || pick_if);
  assign bus.ls_ready = (state_q == ST_IDLE) && pick_ls;
  assign bus.if_ready = (state_q == ST_IDLE) && pick_if;

  // The IFU always fetches a full word.
  assign sel_addr_lo = pick_ls ? bus.ls_addr[1:0] : bus.if_addr[1:0];
  assign sel_fmt     = pick_ls ? bus.ls_format : FMT_W;

  mem_align_chk u_align_chk (
    .addr_lo    (sel_addr_lo),
    .format     (sel_fmt),
    .misaligned (misaligned)
  );

  assign timeout_hit = TO_EN && (tcnt_q == TO_LAST);
  assign rsp_done    = (state_q == ST_RESP) &&
                       ((gnt_q == GNT_LS) ? bus.ls_rready : bus.if_rready);

  // Load data is zero-extended to the access size; the LSU sign-extends.
  always_comb begin
    rd_masked = '0;
    case (fmt_q)
      FMT_B:   rd_masked[7:0]  = bus.mem_rdata[7:0];
      FMT_H:   rd_masked[15:0] = bus.mem_rdata[15:0];
      default: rd_masked       = bus.mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; misaligned requests skip the memory entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = misaligned ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.mem_ack || timeout_hit) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request latch, response capture and WAIT timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= GNT_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      fmt_q   <= FMT_B;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
    end else if (accept) begin
      gnt_q   <= pick_ls ? GNT_LS : GNT_IF;
      addr_q  <= pick_ls ? bus.ls_addr : bus.if_addr;
      we_q    <= pick_ls && bus.ls_we;
      fmt_q   <= sel_fmt;
      wdata_q <= pick_ls ? bus.ls_wdata : '0;
      rdata_q <= '0;
      err_q   <= misaligned;
      tcnt_q  <= '0;
    end else if (state_q == ST_WAIT) begin
      if (bus.mem_ack) begin
        rdata_q <= we_q ? '0 : rd_masked;
        err_q   <= 1'b0;
      end else if (timeout_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end else begin
        tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end

  // Counts consecutive LSU grants that bypassed a waiting IFU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (!bus.if_valid) begin
      starve_q <= '0;
    end else if (bus.if_ready) begin
      starve_q <= '0;
    end else if (bus.ls_ready && (starve_q != STARVE_MAX)) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  // Memory port is driven from the latched request only while in WAIT.
  assign bus.mem_req    = (state_q == ST_WAIT);
  assign bus.mem_we     = bus.mem_req && we_q;
  assign bus.mem_format = bus.mem_req ? fmt_q : 2'b00;
  assign bus.mem_addr   = bus.mem_req ? addr_q : '0;
  assign bus.mem_wdata  = bus.mem_req ? wdata_q : '0;

  // Response channel: only the granted side sees valid and data.
  assign bus.if_rvalid = (state_q == ST_RESP) && (gnt_q == GNT_IF);
  assign bus.ls_rvalid = (state_q == ST_RESP) && (gnt_q == GNT_LS);
  assign bus.if_rdata  = bus.if_rvalid ? rdata_q : '0;
  assign bus.if_rerr   = bus.if_rvalid && err_q;
  assign bus.ls_rdata  = bus.ls_rvalid ? rdata_q : '0;
  assign bus.ls_rerr   = bus.ls_rvalid && err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a table of single transactions plus hand-written
// sequences for arbitration, starvation, timeout/backpressure and reset.
module tb_mem_arbiter;
  import mem_pkg::*;

  logic   clk;
  logic   rst_n;
  state_t fsm_state;

  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .STARVE_LIMIT (4),
    .TIMEOUT      (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  // Memory model: zero-wait ack when enabled, plus an optional stray ack input.
  logic        mem_auto;
  logic        mem_stray;
  logic [31:0] mem_word;
  assign bus.mem_rdata = mem_word;
  assign bus.mem_ack   = (mem_auto && bus.mem_req) || mem_stray;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: act=still running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Waits up to max negedges for a selected DUT signal to be 1.
  task automatic wait_sig(input int which, input int max, output logic ok);
    logic s;
    int n;
    n = 0;
    ok = 1'b0;
    while (!ok && n < max) begin
      @(negedge clk);
      n++;
      case (which)
        0: s = bus.ls_rvalid;
        1: s = bus.if_rvalid;
        2: s = bus.if_ready;
        default: s = bus.ls_ready;
      endcase
      ok = s;
    end
  endtask

  // Issues one request, changes the requester fields after acceptance and
  // collects the response plus the first memory-cycle fields.
  task automatic run_txn(
    input  logic ls, input logic we, input logic [1:0] fmt,
    input  logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] mdata,
    output logic [31:0] rdata, output logic err, output int lat, output logic saw_req,
    output logic [31:0] m_addr, output logic m_we, output logic [1:0] m_fmt,
    output logic [31:0] m_wdata, output logic done);
    logic rdy;
    logic rv;
    int n;
    mem_word = mdata;
    rdata = '0; err = 1'b0; lat = 0; saw_req = 1'b0;
    m_addr = '0; m_we = 1'b0; m_fmt = 2'b00; m_wdata = '0; done = 1'b0;
    rv = 1'b0;
    @(posedge clk); #1;
    if (ls) begin
      bus.ls_valid = 1'b1; bus.ls_we = we; bus.ls_format = fmt;
      bus.ls_addr = addr; bus.ls_wdata = wdata;
    end else begin
      bus.if_valid = 1'b1; bus.if_addr = addr;
    end
    wait_sig(ls ? 3 : 2, 20, rdy);
    if (rdy) begin
      @(posedge clk); #1;
      bus.ls_valid = 1'b0; bus.if_valid = 1'b0;
      bus.ls_addr = ~addr; bus.if_addr = ~addr; bus.ls_wdata = ~wdata;
      bus.ls_we = ~we; bus.ls_format = ~fmt;
      n = 0;
      while (!rv && n < 40) begin
        @(negedge clk);
        n++;
        if (bus.mem_req && !saw_req) begin
          saw_req = 1'b1;
          m_addr = bus.mem_addr; m_we = bus.mem_we;
          m_fmt = bus.mem_format; m_wdata = bus.mem_wdata;
        end
        rv = ls ? bus.ls_rvalid : bus.if_rvalid;
        if (rv) begin
          rdata = ls ? bus.ls_rdata : bus.if_rdata;
          err   = ls ? bus.ls_rerr : bus.if_rerr;
        end
      end
      lat = n;
    end else begin
      bus.ls_valid = 1'b0; bus.if_valid = 1'b0;
    end
    done = rdy && rv;
  endtask

  typedef struct {
    logic        ls;
    logic        we;
    logic [1:0]  fmt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic        exp_req;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] rdata, m_addr, m_wdata;
    logic err, saw_req, m_we, done, ok;
    logic [1:0] m_fmt;
    int lat, n, req_cnt;
    logic held_ok;
    logic [31:0] got;

    // Stimulus table: ls, we, fmt, addr, wdata, mem word, rdata, err, latency, mem access
    vecs[0] = '{1'b0, 1'b0, 2'b10, 32'h8000_0000, 32'h0, 32'h0000_0413, 32'h0000_0413, 1'b0, 2, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 2'b00, 32'h8000_0005, 32'h0, 32'hAABB_CCDD, 32'h0000_00DD, 1'b0, 2, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 2'b01, 32'h8000_0002, 32'h0, 32'hAABB_CCDD, 32'h0000_CCDD, 1'b0, 2, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 2'b10, 32'h8000_0004, 32'h0, 32'h1234_5678, 32'h1234_5678, 1'b0, 2, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 2'b10, 32'h8000_0008, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 1'b0, 2, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 2'b01, 32'h8000_0003, 32'h0000_BEEF, 32'h1234_5678, 32'h0, 1'b1, 1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 2'b10, 32'h8000_0002, 32'h0, 32'h1234_5678, 32'h0, 1'b1, 1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 2'b10, 32'h8000_0002, 32'h0, 32'h1234_5678, 32'h0, 1'b1, 1, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 2'b11, 32'h8000_000C, 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 2, 1'b1};
    vecs[9] = '{1'b1, 1'b1, 2'b00, 32'h8000_0007, 32'h0000_00A5, 32'h1234_5678, 32'h0, 1'b0, 2, 1'b1};

    rst_n = 1'b0;
    mem_auto = 1'b1; mem_stray = 1'b0; mem_word = '0;
    bus.if_valid = 1'b0; bus.if_addr = '0; bus.if_rready = 1'b1;
    bus.ls_valid = 1'b0; bus.ls_we = 1'b0; bus.ls_format = 2'b00;
    bus.ls_addr = '0; bus.ls_wdata = '0; bus.ls_rready = 1'b1;

    // Reset state
    #13;
    check("reset_state", 32'(fsm_state), 32'(ST_IDLE));
    check("reset_mem_req", 32'(bus.mem_req), 32'd0);
    check("reset_rvalid", {30'd0, bus.if_rvalid, bus.ls_rvalid}, 32'd0);
    check("reset_mem_addr", bus.mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single transactions
    for (int i = 0; i < 10; i++) begin
      run_txn(vecs[i].ls, vecs[i].we, vecs[i].fmt, vecs[i].addr, vecs[i].wdata, vecs[i].mdata,
              rdata, err, lat, saw_req, m_addr, m_we, m_fmt, m_wdata, done);
      check($sformatf("v%0d_done", i), 32'(done), 32'd1);
      check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_mem_req", i), 32'(saw_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req) begin
        check($sformatf("v%0d_mem_addr", i), m_addr, vecs[i].addr);
        check($sformatf("v%0d_mem_we", i), 32'(m_we), 32'(vecs[i].we));
        check($sformatf("v%0d_mem_fmt", i), 32'(m_fmt), 32'(vecs[i].ls ? vecs[i].fmt : 2'b10));
        if (vecs[i].we) check($sformatf("v%0d_mem_wdata", i), m_wdata, vecs[i].wdata);
      end
    end

    // Simultaneous valids: LSU first, IFU keeps valid and is served next
    exp_q.push_back(32'h0000_00DD);
    exp_q.push_back(32'h0000_0413);
    mem_word = 32'hAABB_CCDD;
    @(posedge clk); #1;
    bus.ls_valid = 1'b1; bus.ls_we = 1'b0; bus.ls_format = FMT_B; bus.ls_addr = 32'h8000_0005;
    bus.if_valid = 1'b1; bus.if_addr = 32'h8000_0100;
    @(negedge clk);
    check("both_ls_ready", 32'(bus.ls_ready), 32'd1);
    check("both_if_ready", 32'(bus.if_ready), 32'd0);
    @(posedge clk); #1;
    bus.ls_valid = 1'b0;
    wait_sig(0, 20, ok);
    check("both_ls_rvalid", 32'(ok), 32'd1);
    check("both_ls_rdata", bus.ls_rdata, exp_q.pop_front());
    mem_word = 32'h0000_0413;
    wait_sig(2, 20, ok);
    check("both_if_ready_later", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.if_valid = 1'b0;
    wait_sig(1, 20, ok);
    check("both_if_rvalid", 32'(ok), 32'd1);
    check("both_if_rdata", bus.if_rdata, exp_q.pop_front());
    @(posedge clk); #1;

    // Starvation: LSU and IFU valid continuously -> L L L L I L L
    for (int k = 0; k < 7; k++) exp_q.push_back((k == 4) ? 32'd0 : 32'd1);
    mem_word = 32'h1111_2222;
    bus.ls_valid = 1'b1; bus.ls_we = 1'b0; bus.ls_format = FMT_W; bus.ls_addr = 32'h8000_0020;
    bus.if_valid = 1'b1; bus.if_addr = 32'h8000_0200;
    for (int g = 0; g < 7; g++) begin
      n = 0;
      ok = 1'b0;
      while (!ok && n < 20) begin
        @(negedge clk);
        n++;
        ok = bus.ls_ready || bus.if_ready;
      end
      got = bus.ls_ready ? 32'd1 : 32'd0;
      check($sformatf("starve_grant%0d_seen", g), 32'(ok), 32'd1);
      check($sformatf("starve_grant%0d_ls", g), got, exp_q.pop_front());
    end
    @(posedge clk); #1;
    bus.ls_valid = 1'b0; bus.if_valid = 1'b0;
    wait_sig(0, 20, ok);
    @(posedge clk); #1;

    // Timeout with no ack, then response held under backpressure and stray acks
    mem_auto = 1'b0;
    mem_word = 32'h1234_5678;
    bus.ls_rready = 1'b0;
    bus.ls_valid = 1'b1; bus.ls_we = 1'b0; bus.ls_format = FMT_W; bus.ls_addr = 32'h8000_0010;
    wait_sig(3, 20, ok);
    check("to_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.ls_valid = 1'b0;
    n = 0; req_cnt = 0; ok = 1'b0;
    while (!ok && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.mem_req) req_cnt++;
      ok = bus.ls_rvalid;
    end
    check("to_rvalid", 32'(ok), 32'd1);
    check("to_req_cycles", 32'(req_cnt), 32'd8);
    check("to_rerr", 32'(bus.ls_rerr), 32'd1);
    check("to_rdata", bus.ls_rdata, 32'd0);
    mem_stray = 1'b1;
    held_ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!(bus.ls_rvalid && bus.ls_rerr && bus.ls_rdata == 32'd0 && !bus.mem_req)) held_ok = 1'b0;
    end
    check("to_held_stable", 32'(held_ok), 32'd1);
    #1;
    mem_stray = 1'b0;
    bus.ls_rready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("to_released", 32'(bus.ls_rvalid), 32'd0);
    check("to_idle", 32'(fsm_state), 32'(ST_IDLE));

    // Reset asserted while in WAIT
    @(posedge clk); #1;
    bus.if_valid = 1'b1; bus.if_addr = 32'h8000_0040;
    wait_sig(2, 20, ok);
    check("rst_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.if_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_req", 32'(bus.mem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_rvalid", {30'd0, bus.if_rvalid, bus.ls_rvalid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_auto = 1'b1;
    run_txn(1'b0, 1'b0, 2'b10, 32'h8000_0000, 32'h0, 32'h0000_0413,
            rdata, err, lat, saw_req, m_addr, m_we, m_fmt, m_wdata, done);
    check("post_rst_done", 32'(done), 32'd1);
    check("post_rst_rdata", rdata, 32'h0000_0413);
    check("post_rst_err", 32'(err), 32'd0);
    check("post_rst_lat", 32'(lat), 32'd2);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
